// File: rtl/codec_frame_serializer.sv
// codec_frame_serializer
//   Generates the audio frame timing (one-clk new_frame strobe every
//   128*BCLK_HALF clk). It latches one sample per frame and shifts it out
//   MSB-first in I2S format. The same sample goes in both the left and the
//   right slot.
//
// Ports
//   clk        system clock (the only clock)
//   reset      asynchronous active-low reset
//   sample_in  sample to transmit, captured only at frame start
//   mute       transmit zeros, captured only at frame start
//   new_frame  one-clk pulse at each frame start
//   bclk       serial bit clock, clk / (2*BCLK_HALF), 50% duty
//   lrclk      word select: 0 = left slot, 1 = right slot
//   sdata      serial data, updates only on bclk falling edges
module codec_frame_serializer #(
    parameter int BCLK_HALF    = 16,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    mute,
    output logic                    new_frame,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata
);

    localparam int DW = $clog2(BCLK_HALF);
    localparam int IW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    logic [DW-1:0]           div_q, div_d;
    logic                    bclk_q, bclk_d;
    logic [5:0]              pos_q, pos_d;
    logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic                    nf_q, nf_d;

    logic                    tick;
    logic                    tick_fall;
    logic [4:0]              slot_s;
    logic [IW-1:0]           bit_idx;

    assign tick      = (div_q == DW'(BCLK_HALF - 1));
    assign tick_fall = tick & bclk_q;

    always_comb begin
        div_d   = div_q;
        bclk_d  = bclk_q;
        pos_d   = pos_q;
        shreg_d = shreg_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        nf_d    = 1'b0;
        slot_s  = '0;
        bit_idx = '0;

        if (tick) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (tick_fall) begin
            pos_d = pos_q + 6'd1;
            // pos wraps 63->0 at frame start. This is the only point where the
            // inputs are sampled. Both slots reuse the same shreg contents.
            if (pos_d == 6'd0) begin
                shreg_d = mute ? '0 : sample_in;
                nf_d    = 1'b1;
            end
            lrclk_d = pos_d[5];
            slot_s  = pos_d[4:0];
            // Slot bit 0 is the I2S one-bit delay. Bits past the LSB are
            // zero padding. Slot bit 0 never reads shreg, so the reload
            // above does not have to be forwarded.
            sdata_d = 1'b0;
            if (slot_s != 5'd0 && {1'b0, slot_s} <= 6'(SAMPLE_WIDTH)) begin
                bit_idx = IW'(SAMPLE_WIDTH - int'(slot_s));
                sdata_d = shreg_q[bit_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            pos_q   <= 6'd63;
            shreg_q <= '0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            pos_q   <= pos_d;
            shreg_q <= shreg_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            nf_q    <= nf_d;
        end
    end

    assign new_frame = nf_q;
    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign sdata     = sdata_q;

endmodule
